// File: rtl/multicycle_controller.sv
// Control FSM for the 8-bit TinyMIPS multicycle datapath: four-byte fetch, decode,
// per-class execute/writeback states, with mem_ready stalling the memory-facing states.
//
// state    | code | meaning
// ---------+------+--------------------------------------------------
// FETCH1-4 | 0-3  | read instruction byte k, load IR byte, PC += 1
// DECODE   | 4    | branch target precompute, dispatch on op
// MEMADR   | 5    | effective address for LB/SB
// LBRD     | 6    | data read, held until mem_ready
// LBWR     | 7    | MDR -> rt
// SBWR     | 8    | data write, held until mem_ready
// RTYPEEX  | 9    | A funct B
// RTYPEWR  | 10   | ALUOut -> rd
// BEQEX    | 11   | A - B, load PC from ALUOut if zero
// JEX      | 12   | PC <= jump target
// ADDIEX   | 13   | A + imm
// ADDIWR   | 14   | ALUOut -> rt
// (15)     | 15   | illegal, recovers to FETCH1
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     r_state;
    state_t     w_next;
    logic       w_memread;
    logic       w_memwrite;
    logic [3:0] w_irwrite;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_regwrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH1;
        case (r_state)
            S_FETCH1:  w_next = mem_ready ? S_FETCH2 : S_FETCH1;
            S_FETCH2:  w_next = mem_ready ? S_FETCH3 : S_FETCH2;
            S_FETCH3:  w_next = mem_ready ? S_FETCH4 : S_FETCH3;
            S_FETCH4:  w_next = mem_ready ? S_DECODE : S_FETCH4;
            S_DECODE: begin
                case (op)
                    OP_LB, OP_SB: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_J:         w_next = S_JEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default:      w_next = S_FETCH1;
                endcase
            end
            S_MEMADR:  w_next = (op == OP_LB) ? S_LBRD : S_SBWR;
            S_LBRD:    w_next = mem_ready ? S_LBWR : S_LBRD;
            S_LBWR:    w_next = S_FETCH1;
            S_SBWR:    w_next = mem_ready ? S_FETCH1 : S_SBWR;
            S_RTYPEEX: w_next = S_RTYPEWR;
            S_RTYPEWR: w_next = S_FETCH1;
            S_BEQEX:   w_next = S_FETCH1;
            S_JEX:     w_next = S_FETCH1;
            S_ADDIEX:  w_next = S_ADDIWR;
            S_ADDIWR:  w_next = S_FETCH1;
            default:   w_next = S_FETCH1;
        endcase
    end

    always_comb begin
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        iord       = 1'b0;
        w_irwrite  = 4'b0000;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        w_regwrite = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        case (r_state)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                w_memread = 1'b1;
                alusrcb   = 2'b01;
                if (mem_ready) begin
                    w_irwrite = 4'b0001 << r_state[1:0];
                    w_pcwrite = 1'b1;
                end
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_LBRD: begin
                w_memread = 1'b1;
                iord      = 1'b1;
            end
            S_LBWR: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
            end
            S_SBWR: begin
                w_memwrite = 1'b1;
                iord       = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWR: begin
                w_regwrite = 1'b1;
                regdst     = 1'b1;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                w_branch = 1'b1;
                pcsrc    = 2'b01;
            end
            S_JEX: begin
                w_pcwrite = 1'b1;
                pcsrc     = 2'b10;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWR:  w_regwrite = 1'b1;
            default: ;
        endcase
    end

    // Strobes are gated by rst_n so an abandoned instruction cannot write during reset.
    assign memread  = w_memread  & rst_n;
    assign memwrite = w_memwrite & rst_n;
    assign irwrite  = w_irwrite  & {4{rst_n}};
    assign pcen     = (w_pcwrite | (w_branch & zero)) & rst_n;
    assign regwrite = w_regwrite & rst_n;
    assign state    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected state and
// control vector are queued as stimulus is driven and compared at the falling edge.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic [3:0] irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [3:0] state;

    int n_cmp;
    int n_bad;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [17:0] ctl;
    } exp_t;

    exp_t sb_q[$];

    multicycle_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .memread   (memread),
        .memwrite  (memwrite),
        .iord      (iord),
        .irwrite   (irwrite),
        .pcen      (pcen),
        .pcsrc     (pcsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .regwrite  (regwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {memread, memwrite, iord, irwrite[3:0], pcen, pcsrc, alusrca, alusrcb, aluop, regwrite, regdst, memtoreg}
    logic [17:0] w_ctl;
    assign w_ctl = {memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca,
                    alusrcb, aluop, regwrite, regdst, memtoreg};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic mr, input logic mw, input logic io,
                                       input logic [3:0] irw, input logic pe,
                                       input logic [1:0] ps, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] ao,
                                       input logic rw, input logic rd, input logic m2r);
        return {mr, mw, io, irw, pe, ps, sa, sb, ao, rw, rd, m2r};
    endfunction

    // Expected controls written from the state descriptions.
    function automatic logic [17:0] exp_ctl(input logic [3:0] st, input logic rdy, input logic z);
        case (st)
            4'd0:  return mk(1,0,0, rdy ? 4'b0001 : 4'b0000, rdy, 2'b00, 0, 2'b01, 2'b00, 0,0,0);
            4'd1:  return mk(1,0,0, rdy ? 4'b0010 : 4'b0000, rdy, 2'b00, 0, 2'b01, 2'b00, 0,0,0);
            4'd2:  return mk(1,0,0, rdy ? 4'b0100 : 4'b0000, rdy, 2'b00, 0, 2'b01, 2'b00, 0,0,0);
            4'd3:  return mk(1,0,0, rdy ? 4'b1000 : 4'b0000, rdy, 2'b00, 0, 2'b01, 2'b00, 0,0,0);
            4'd4:  return mk(0,0,0, 4'b0000, 0, 2'b00, 0, 2'b11, 2'b00, 0,0,0);
            4'd5:  return mk(0,0,0, 4'b0000, 0, 2'b00, 1, 2'b10, 2'b00, 0,0,0);
            4'd6:  return mk(1,0,1, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, 0,0,0);
            4'd7:  return mk(0,0,0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, 1,0,1);
            4'd8:  return mk(0,1,1, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, 0,0,0);
            4'd9:  return mk(0,0,0, 4'b0000, 0, 2'b00, 1, 2'b00, 2'b10, 0,0,0);
            4'd10: return mk(0,0,0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, 1,1,0);
            4'd11: return mk(0,0,0, 4'b0000, z, 2'b01, 1, 2'b00, 2'b01, 0,0,0);
            4'd12: return mk(0,0,0, 4'b0000, 1, 2'b10, 0, 2'b00, 2'b00, 0,0,0);
            4'd13: return mk(0,0,0, 4'b0000, 0, 2'b00, 1, 2'b10, 2'b00, 0,0,0);
            4'd14: return mk(0,0,0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00, 1,0,0);
            default: return 18'h0;
        endcase
    endfunction

    // Drive one cycle's inputs, queue the expectation, and advance to just after the next edge.
    task automatic step(input string tag, input logic [5:0] o, input logic z,
                        input logic rdy, input logic [3:0] st);
        exp_t e;
        op        = o;
        zero      = z;
        mem_ready = rdy;
        e.tag = tag;
        e.st  = st;
        e.ctl = exp_ctl(st, rdy, z);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [5:0] o);
        for (int k = 0; k < 4; k++) step(tag, o, 1'b0, 1'b1, 4'(k));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({e.tag, ".state"}, 32'(state), 32'(e.st));
            check_val({e.tag, ".ctl"},   32'(w_ctl), 32'(e.ctl));
        end
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        op        = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #3;
        check_val("rst.state", 32'(state), 32'd0);
        check_val("rst.ctl",   32'(w_ctl), 32'h00020);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_hold.state", 32'(state), 32'd0);
        rst_n = 1'b1;

        // R-type: 0,1,2,3,4,9,10
        fetch("rtype", 6'b000000);
        step("rtype", 6'b000000, 0, 1, 4'd4);
        step("rtype", 6'b000000, 0, 1, 4'd9);
        step("rtype", 6'b000000, 0, 1, 4'd10);

        // LB with a one-cycle stall in LBRD: 9 cycles
        fetch("lb", 6'b100000);
        step("lb", 6'b100000, 0, 1, 4'd4);
        step("lb", 6'b100000, 0, 1, 4'd5);
        step("lb", 6'b100000, 0, 0, 4'd6);
        step("lb", 6'b100000, 0, 1, 4'd6);
        step("lb", 6'b100000, 0, 1, 4'd7);

        // BEQ taken and not taken
        fetch("beq_t", 6'b000100);
        step("beq_t", 6'b000100, 1, 1, 4'd4);
        step("beq_t", 6'b000100, 1, 1, 4'd11);
        fetch("beq_n", 6'b000100);
        step("beq_n", 6'b000100, 0, 1, 4'd4);
        step("beq_n", 6'b000100, 0, 1, 4'd11);

        // J with 3 stall cycles in FETCH2
        step("j_stall", 6'b000010, 0, 1, 4'd0);
        step("j_stall", 6'b000010, 0, 0, 4'd1);
        step("j_stall", 6'b000010, 0, 0, 4'd1);
        step("j_stall", 6'b000010, 0, 0, 4'd1);
        step("j_stall", 6'b000010, 0, 1, 4'd1);
        step("j_stall", 6'b000010, 0, 1, 4'd2);
        step("j_stall", 6'b000010, 0, 1, 4'd3);
        step("j_stall", 6'b000010, 0, 1, 4'd4);
        step("j_stall", 6'b000010, 0, 1, 4'd12);

        // Illegal op behaves as NOP
        fetch("nop", 6'b111111);
        step("nop", 6'b111111, 1, 1, 4'd4);

        // ADDI, with stall in FETCH1
        step("addi", 6'b001000, 0, 0, 4'd0);
        fetch("addi", 6'b001000);
        step("addi", 6'b001000, 0, 1, 4'd4);
        step("addi", 6'b001000, 0, 1, 4'd13);
        step("addi", 6'b001000, 0, 1, 4'd14);

        // SB, mem_ready low is ignored in DECODE/MEMADR
        fetch("sb", 6'b101000);
        step("sb", 6'b101000, 0, 0, 4'd4);
        step("sb", 6'b101000, 0, 0, 4'd5);
        step("sb", 6'b101000, 0, 1, 4'd8);

        // R-type with mem_ready low outside fetch
        fetch("rt_nr", 6'b000000);
        step("rt_nr", 6'b000000, 0, 0, 4'd4);
        step("rt_nr", 6'b000000, 0, 0, 4'd9);
        step("rt_nr", 6'b000000, 0, 0, 4'd10);

        // SB stalled in SBWR, then asynchronous reset mid-cycle
        fetch("sb_rst", 6'b101000);
        step("sb_rst", 6'b101000, 0, 1, 4'd4);
        step("sb_rst", 6'b101000, 0, 1, 4'd5);
        step("sb_rst", 6'b101000, 0, 0, 4'd8);
        step("sb_rst", 6'b101000, 0, 0, 4'd8);
        #1;
        check_val("sbwr_hold.state",    32'(state),    32'd8);
        check_val("sbwr_hold.memwrite", 32'(memwrite), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("async_rst.state",    32'(state),    32'd0);
        check_val("async_rst.memwrite", 32'(memwrite), 32'd0);
        check_val("async_rst.ctl",      32'(w_ctl),    32'h00020);
        @(posedge clk);
        #1;
        check_val("rst_edge.state",     32'(state),    32'd0);
        check_val("rst_edge.regwrite",  32'(regwrite), 32'd0);
        rst_n = 1'b1;
        fetch("post_rst", 6'b000000);
        step("post_rst", 6'b000000, 0, 1, 4'd4);
        step("post_rst", 6'b000000, 0, 1, 4'd9);
        step("post_rst", 6'b000000, 0, 1, 4'd10);
        step("post_rst", 6'b000000, 0, 1, 4'd0);

        @(negedge clk);
        #1;
        check_val("sb_q_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
